// File: rtl/fatori_data_mem_resp.sv
// Single-port data memory for the LSU side: combinational grant, fixed-latency
// in-order responses, bus-error detection and saturating performance counters.
module fatori_data_mem_resp #(
   parameter int          Depth    = 1024,
   parameter logic [31:0] BaseAddr = 32'h0000_0000,
   parameter int          Latency  = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   input  logic        stall_i,
   input  logic        inject_err_i,
   output logic [2:0]  outstanding_o,
   output logic [15:0] perf_rd_o,
   output logic [15:0] perf_wr_o,
   output logic [15:0] perf_err_o
);

   localparam int          AW        = $clog2(Depth);
   localparam logic [31:0] SizeBytes = 32'(Depth * 4);

   logic [31:0]               r_mem [Depth];
   logic                      r_armed;
   logic [Latency-1:0]        r_pipeVld;
   logic [Latency-1:0]        r_pipeErr;
   logic [Latency-1:0]        r_pipeWe;
   logic [Latency-1:0][31:0]  r_pipeData;
   logic [2:0]                r_outstanding;
   logic [15:0]               r_perfRd;
   logic [15:0]               r_perfWr;
   logic [15:0]               r_perfErr;

   logic          w_gnt;
   logic [31:0]   w_off;
   logic [AW-1:0] w_idx;
   logic          w_err;
   logic          w_resp;

   // Subtracting the base lets one unsigned compare cover both range ends.
   assign w_gnt  = data_req_i & ~stall_i & rst_ni;
   assign w_off  = data_addr_i - BaseAddr;
   assign w_idx  = w_off[AW+1:2];
   assign w_err  = (w_off >= SizeBytes) | (data_addr_i[1:0] != 2'b00) |
                   (data_be_i == 4'b0000) | r_armed | inject_err_i;
   assign w_resp = r_pipeVld[Latency-1];

   // The array has no reset so its contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (w_gnt && data_we_i && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Idle slots carry zeros, so rdata/err stay 0 whenever rvalid is low.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pipeVld  <= '0;
         r_pipeErr  <= '0;
         r_pipeWe   <= '0;
         r_pipeData <= '0;
      end else begin
         r_pipeVld[0]  <= w_gnt;
         r_pipeErr[0]  <= w_gnt & w_err;
         r_pipeWe[0]   <= w_gnt & data_we_i;
         r_pipeData[0] <= (w_gnt && !w_err && !data_we_i) ? r_mem[w_idx] : 32'h0;
         for (int i = 1; i < Latency; i++) begin
            r_pipeVld[i]  <= r_pipeVld[i-1];
            r_pipeErr[i]  <= r_pipeErr[i-1];
            r_pipeWe[i]   <= r_pipeWe[i-1];
            r_pipeData[i] <= r_pipeData[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_armed       <= 1'b0;
         r_outstanding <= 3'd0;
      end else begin
         if (w_gnt) begin
            r_armed <= 1'b0;
         end else if (inject_err_i) begin
            r_armed <= 1'b1;
         end
         case ({w_gnt, w_resp})
            2'b10:   r_outstanding <= r_outstanding + 3'd1;
            2'b01:   r_outstanding <= r_outstanding - 3'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_perfRd  <= 16'h0;
         r_perfWr  <= 16'h0;
         r_perfErr <= 16'h0;
      end else if (w_resp) begin
         if (r_pipeErr[Latency-1]) begin
            if (r_perfErr != 16'hFFFF) r_perfErr <= r_perfErr + 16'd1;
         end else if (r_pipeWe[Latency-1]) begin
            if (r_perfWr != 16'hFFFF) r_perfWr <= r_perfWr + 16'd1;
         end else begin
            if (r_perfRd != 16'hFFFF) r_perfRd <= r_perfRd + 16'd1;
         end
      end
   end

   assign data_gnt_o    = w_gnt;
   assign data_rvalid_o = r_pipeVld[Latency-1];
   assign data_err_o    = r_pipeErr[Latency-1];
   assign data_rdata_o  = r_pipeData[Latency-1];
   assign outstanding_o = r_outstanding;
   assign perf_rd_o     = r_perfRd;
   assign perf_wr_o     = r_perfWr;
   assign perf_err_o    = r_perfErr;

endmodule
